sort_stream: RTL and testbench
==============================

// Module: sort_stream
// PURPOSE
//  Single-clock packet sorter. Buffers one packet of up to MAX_LENGTH {key,payload} beats,
//  insertion-sorts on arrival, replays the packet in key order with sop/eop framing.
//  Adds payload carriage, runtime direction, stable ties, src backpressure, over-length handling.
//  Sits between the ingest framer and the downstream packet consumer.
// PARAMETERS
//  KEY_WIDTH   8   sort key width, unsigned compare
//  DATA_WIDTH  8   payload width, carried unchanged with its key
//  MAX_LENGTH  16  slots; packet beats stored; >=2
// PORTS
//  clock      in  1           single clock, rising edge
//  reset_n    in  1           asynchronous, active-low reset
//  snk_ready  out 1           sink may accept a beat
//  snk_valid  in  1           sink beat valid
//  snk_sop    in  1           first beat of packet
//  snk_eop    in  1           last beat of packet
//  snk_key    in  KEY_WIDTH   sort key
//  snk_data   in  DATA_WIDTH  payload
//  sort_desc  in  1           0 ascending, 1 descending; sampled at sop acceptance
//  src_ready  in  1           downstream accepts beat
//  src_valid  out 1           output beat valid
//  src_sop    out 1           first sorted beat
//  src_eop    out 1           last sorted beat
//  src_key    out KEY_WIDTH   sorted key
//  src_data   out DATA_WIDTH  payload of src_key
//  src_err    out 1           only with SORT_STREAM_ERR_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset: state IDLE, snk_ready=1, src_valid/sop/eop/err=0, src_key/data=0, count=0, slots empty.
//  Beat accepted = snk_valid & snk_ready. Transfer = src_valid & src_ready.
//  FSM IDLE -> LOAD -> DRAIN -> IDLE.
//   IDLE : snk_ready=1. Accepted beat with sop -> insert, latch sort_desc, LOAD
//          (sop&eop -> DRAIN directly). Accepted beat without sop dropped.
//   LOAD : snk_ready=1. Each accepted beat inserted same cycle; snk_sop ignored mid-packet.
//          Accepted eop -> DRAIN, snk_ready=0 from next cycle.
//   DRAIN: snk_ready=0. Cycle after eop acceptance: src_valid=1, src_sop=1, first sorted beat.
//          Each transfer advances rd index; src_eop=1 on beat index count-1.
//          Outputs held stable while src_valid & ~src_ready. Transfer with src_eop -> IDLE;
//          next cycle src_valid=0, snk_ready=1, count=0, slots empty.
//  Insertion: slots 0..count-1 always sorted. Insert position p = number of valid slots with
//   key <= new (asc) or key >= new (desc); slots >=p shift up one, new beat written at p.
//   Equal keys keep arrival order (stable). One insert per cycle, no stall.
//  Overflow: beats after MAX_LENGTH stored are dropped; count saturates at MAX_LENGTH;
//   eop on a dropped beat still ends LOAD. Output length = min(beats, MAX_LENGTH).
//  count is $clog2(MAX_LENGTH+1) bits; rd index same width; no wrap.
//  reset_n low at any time aborts packet immediately, returns to reset values.
// CONFIGURATION
//  SORT_STREAM_ERR_EN defined: src_err port exists; src_err=1 on src_eop beat of a packet that
//   overflowed, else 0; cleared on leaving DRAIN.
//  Undefined: no src_err port; overflow beats dropped silently.
// STRUCTURE
//  sort_stream_pkg: state enum typedef (IDLE, LOAD, DRAIN), slot struct {valid,key,data}
//   parametrised via module typedefs, compare helper function (asc/desc, tie rule).
//  Sub-module sort_stream_slot: one slot register; inputs neighbour slot, new beat,
//   shift/write/clear selects; MAX_LENGTH instances in generate loop.
// TESTING
//  Asc, 5 beats keys 7,3,9,3,1 payloads A..E -> out keys 1,3,3,7,9 payloads E,B,D,A,C; sop on 1, eop on 9.
//  sort_desc=1, keys 2,8,5 -> out 8,5,2; sort_desc toggled mid-packet has no effect.
//  Single beat sop&eop key 4 -> one output beat, src_sop=src_eop=1, snk_ready low one+ cycles.
//  20 beats keys 20..1, MAX_LENGTH=16 -> 16 beats out, keys 5..20 asc; src_err=1 on eop if _EN.
//  src_ready low random 50% during drain -> no beat lost/duplicated, outputs stable while stalled.
//  reset_n asserted mid-LOAD and mid-DRAIN -> all outputs at reset values; next packet sorts cleanly.

Source files
------------

// File: rtl/sort_stream_pkg.sv
// Shared types and the key-ordering helper for the sort_stream packet sorter.
package sort_stream_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    localparam int unsigned MaxKeyWidth = 32;

    // True when a stored key stays ahead of an incoming key; ties keep arrival order.
    function automatic logic key_stays_ahead(input logic [MaxKeyWidth-1:0] slot_key,
                                             input logic [MaxKeyWidth-1:0] new_key,
                                             input logic                   desc);
        return desc ? (slot_key >= new_key) : (slot_key <= new_key);
    endfunction

endpackage

// File: rtl/sort_stream_slot.sv
// One storage slot of the sorter: clear, write new beat, or shift in the lower neighbour.
module sort_stream_slot #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] prev_slot,
    input  logic [WIDTH-1:0] new_slot,
    input  logic             shift,
    input  logic             write,
    input  logic             clear,
    output logic [WIDTH-1:0] slot
);

    logic [WIDTH-1:0] slot_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
        end else if (clear) begin
            slot_q <= '0;
        end else if (write) begin
            slot_q <= new_slot;
        end else if (shift) begin
            slot_q <= prev_slot;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/sort_stream.sv
// Single-packet insertion sorter with sop/eop framing and src backpressure.
// Optional src_err overflow flag enabled by defining SORT_STREAM_ERR_EN.
module sort_stream
    import sort_stream_pkg::*;
#(
    parameter int unsigned KEY_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_LENGTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  snk_ready,
    input  logic                  snk_valid,
    input  logic                  snk_sop,
    input  logic                  snk_eop,
    input  logic [KEY_WIDTH-1:0]  snk_key,
    input  logic [DATA_WIDTH-1:0] snk_data,
    input  logic                  sort_desc,
    input  logic                  src_ready,
    output logic                  src_valid,
    output logic                  src_sop,
    output logic                  src_eop,
    output logic [KEY_WIDTH-1:0]  src_key,
`ifdef SORT_STREAM_ERR_EN
    output logic                  src_err,
`endif
    output logic [DATA_WIDTH-1:0] src_data
);

    localparam int unsigned CW = $clog2(MAX_LENGTH + 1);
    localparam int unsigned SW = 1 + KEY_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_q, rd_d;
    logic            desc_q;
    slot_t           slots [MAX_LENGTH];
    slot_t           new_slot;
    logic [MAX_LENGTH-1:0] stays, prev_stays, write, shift;
    logic            accept, xfer, insert, desc_eff, drain_done;

    assign accept     = snk_valid & snk_ready;
    assign xfer       = src_valid & src_ready;
    assign drain_done = xfer & src_eop;
    assign insert     = accept & ((state_q != StIdle) | snk_sop) & (count_q < CW'(MAX_LENGTH));
    assign desc_eff   = (state_q == StIdle) ? sort_desc : desc_q;
    assign new_slot   = '{valid: 1'b1, key: snk_key, data: snk_data};

    // Kept slots form a prefix; the first non-kept slot takes the new beat, the rest shift up.
    always_comb begin
        stays = '0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            stays[i] = slots[i].valid &
                       key_stays_ahead(MaxKeyWidth'(slots[i].key), MaxKeyWidth'(snk_key), desc_eff);
        end
        prev_stays = {stays[MAX_LENGTH-2:0], 1'b1};
        write      = insert ? (~stays & prev_stays) : '0;
        shift      = insert ? (~stays & ~prev_stays) : '0;
    end

    for (genvar g = 0; g < MAX_LENGTH; g++) begin : g_slot
        logic [SW-1:0] prev_vec;
        if (g == 0) begin : g_first
            assign prev_vec = '0;
        end else begin : g_rest
            assign prev_vec = slots[g-1];
        end
        sort_stream_slot #(
            .WIDTH(SW)
        ) u_slot (
            .clock    (clock),
            .reset_n  (reset_n),
            .prev_slot(prev_vec),
            .new_slot (new_slot),
            .shift    (shift[g]),
            .write    (write[g]),
            .clear    (drain_done),
            .slot     (slots[g])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            rd_q    <= '0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            if (state_q == StIdle && accept && snk_sop) desc_q <= sort_desc;
        end
    end

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        if (drain_done) begin
            count_d = '0;
            rd_d    = '0;
        end else begin
            if (insert) count_d = count_q + CW'(1);
            if (xfer)   rd_d    = rd_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && snk_sop) state_d = snk_eop ? StDrain : StLoad;
            StLoad:  if (accept && snk_eop) state_d = StDrain;
            StDrain: if (drain_done)        state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        snk_ready = (state_q != StDrain);
        src_valid = (state_q == StDrain);
        src_sop   = src_valid & (rd_q == '0);
        src_eop   = src_valid & (rd_q == count_q - CW'(1));
        src_key   = '0;
        src_data  = '0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (src_valid && rd_q == CW'(i)) begin
                src_key  = slots[i].key;
                src_data = slots[i].data;
            end
        end
    end

`ifdef SORT_STREAM_ERR_EN
    logic overflow_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (drain_done) begin
            overflow_q <= 1'b0;
        end else if (state_q == StLoad && accept && count_q == CW'(MAX_LENGTH)) begin
            overflow_q <= 1'b1;
        end
    end

    assign src_err = src_eop & overflow_q;
`endif

endmodule

// File: tb/tb_sort_stream.sv
// Self-checking bench for sort_stream: directed cases plus randomized packets vs a selection-sort model.
module tb_sort_stream;

    localparam int KW = 8;
    localparam int DW = 8;
    localparam int ML = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          snk_ready, snk_valid, snk_sop, snk_eop, sort_desc;
    logic [KW-1:0] snk_key, src_key;
    logic [DW-1:0] snk_data, src_data;
    logic          src_ready, src_valid, src_sop, src_eop;
`ifdef SORT_STREAM_ERR_EN
    logic          src_err;
`endif

    int passes = 0;
    int total  = 0;

    int in_key[$];
    int in_data[$];
    int exp_key[$];
    int exp_data[$];
    bit exp_ovf;

    sort_stream #(
        .KEY_WIDTH (KW),
        .DATA_WIDTH(DW),
        .MAX_LENGTH(ML)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .snk_ready(snk_ready),
        .snk_valid(snk_valid),
        .snk_sop  (snk_sop),
        .snk_eop  (snk_eop),
        .snk_key  (snk_key),
        .snk_data (snk_data),
        .sort_desc(sort_desc),
        .src_ready(src_ready),
        .src_valid(src_valid),
        .src_sop  (src_sop),
        .src_eop  (src_eop),
        .src_key  (src_key),
`ifdef SORT_STREAM_ERR_EN
        .src_err  (src_err),
`endif
        .src_data (src_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_snk_ready"}, 32'(snk_ready), 32'd1);
        check({tag, "_src_valid"}, 32'(src_valid), 32'd0);
        check({tag, "_src_sop"},   32'(src_sop),   32'd0);
        check({tag, "_src_eop"},   32'(src_eop),   32'd0);
        check({tag, "_src_key"},   32'(src_key),   32'd0);
        check({tag, "_src_data"},  32'(src_data),  32'd0);
`ifdef SORT_STREAM_ERR_EN
        check({tag, "_src_err"},   32'(src_err),   32'd0);
`endif
    endtask

    // Stable selection sort of the stored beats: pick extreme key, earliest on ties.
    function automatic void build_expected(input bit desc);
        int k[$];
        int d[$];
        int best;
        exp_key.delete();
        exp_data.delete();
        for (int i = 0; i < in_key.size() && i < ML; i++) begin
            k.push_back(in_key[i]);
            d.push_back(in_data[i]);
        end
        exp_ovf = (in_key.size() > ML);
        while (k.size() > 0) begin
            best = 0;
            for (int j = 1; j < k.size(); j++) begin
                if (desc ? (k[j] > k[best]) : (k[j] < k[best])) best = j;
            end
            exp_key.push_back(k[best]);
            exp_data.push_back(d[best]);
            k.delete(best);
            d.delete(best);
        end
    endfunction

    // sort_desc is inverted on every non-sop beat; it must only be honoured at sop.
    task automatic send_packet(input bit desc);
        for (int i = 0; i < in_key.size(); i++) begin
            @(negedge clock);
            check("snk_ready_load", 32'(snk_ready), 32'd1);
            snk_valid = 1'b1;
            snk_sop   = (i == 0);
            snk_eop   = (i == in_key.size() - 1);
            snk_key   = KW'(in_key[i]);
            snk_data  = DW'(in_data[i]);
            sort_desc = (i == 0) ? desc : ~desc;
        end
        @(negedge clock);
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        check("snk_ready_drain", 32'(snk_ready), 32'd0);
    endtask

    task automatic receive(input int ready_pct);
        int idx = 0;
        int cyc = 0;
        bit stalled = 0;
        bit r;
        logic [KW-1:0] h_key;
        logic [DW-1:0] h_data;
        logic h_sop, h_eop;
        while (idx < exp_key.size() && cyc < 2000) begin
            if (src_valid) begin
                if (stalled) begin
                    check("hold_key",  32'(src_key),  32'(h_key));
                    check("hold_data", 32'(src_data), 32'(h_data));
                    check("hold_sop",  32'(src_sop),  32'(h_sop));
                    check("hold_eop",  32'(src_eop),  32'(h_eop));
                end
                r = ($urandom_range(99) < ready_pct);
                src_ready = r;
                if (r) begin
                    check("out_key",  32'(src_key),  32'(exp_key[idx]));
                    check("out_data", 32'(src_data), 32'(exp_data[idx]));
                    check("out_sop",  32'(src_sop),  32'(idx == 0));
                    check("out_eop",  32'(src_eop),  32'(idx == exp_key.size() - 1));
`ifdef SORT_STREAM_ERR_EN
                    check("out_err",  32'(src_err),
                          32'(exp_ovf && idx == exp_key.size() - 1));
`endif
                    idx++;
                end
                stalled = !r;
                h_key = src_key; h_data = src_data; h_sop = src_sop; h_eop = src_eop;
            end else begin
                src_ready = 1'b0;
                stalled   = 0;
            end
            @(negedge clock);
            cyc++;
        end
        src_ready = 1'b0;
        check("drain_beats", 32'(idx), 32'(exp_key.size()));
        check("post_src_valid", 32'(src_valid), 32'd0);
        check("post_snk_ready", 32'(snk_ready), 32'd1);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        snk_valid = 1'b0;
        src_ready = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run(input bit desc, input int ready_pct);
        build_expected(desc);
        send_packet(desc);
        receive(ready_pct);
    endtask

    initial begin
        snk_valid = 0; snk_sop = 0; snk_eop = 0; snk_key = 0; snk_data = 0;
        sort_desc = 0; src_ready = 0;
        #3;
        check_reset_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Stray non-sop beat in idle must be dropped.
        @(negedge clock);
        snk_valid = 1; snk_sop = 0; snk_eop = 0; snk_key = 8'h00; snk_data = 8'h55;
        @(negedge clock);
        snk_valid = 0;

        in_key  = '{7, 3, 9, 3, 1};
        in_data = '{8'hA, 8'hB, 8'hC, 8'hD, 8'hE};
        run(1'b0, 100);

        in_key  = '{2, 8, 5};
        in_data = '{8'h21, 8'h22, 8'h23};
        run(1'b1, 100);

        in_key  = '{4};
        in_data = '{8'h44};
        run(1'b0, 100);

        in_key.delete();
        in_data.delete();
        for (int i = 0; i < 20; i++) begin
            in_key.push_back(20 - i);
            in_data.push_back(8'h80 + i);
        end
        run(1'b0, 50);

        for (int p = 0; p < 6; p++) begin
            int n = $urandom_range(1, 20);
            in_key.delete();
            in_data.delete();
            for (int i = 0; i < n; i++) begin
                in_key.push_back($urandom_range(0, 7));
                in_data.push_back($urandom_range(0, 255));
            end
            run(1'($urandom_range(0, 1)), 50);
        end

        // Abort mid-load.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            snk_valid = 1; snk_sop = (i == 0); snk_eop = 0;
            snk_key = KW'(9 - i); snk_data = DW'(i); sort_desc = 0;
        end
        pulse_reset("rst_load");

        // Abort mid-drain after one transfer.
        in_key  = '{6, 1, 5};
        in_data = '{8'h61, 8'h62, 8'h63};
        build_expected(1'b0);
        send_packet(1'b0);
        src_ready = 1'b1;
        @(negedge clock);
        src_ready = 1'b0;
        check("mid_drain_key", 32'(src_key), 32'd5);
        pulse_reset("rst_drain");

        in_key  = '{30, 10, 20, 10};
        in_data = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(1'b0, 60);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
